// File: rtl/count_timer.sv
// Countdown game timer: loads a preset in seconds, counts down at 1 Hz, shows two BCD digits and
// hands off to the beep_beep alarm stage. Optional final-seconds warning: define COUNT_TIMER_WARN_EN.
module count_timer #(
    parameter int CLK_HZ       = 1000,
    parameter int ALARM_TO_SEC = 3
) (
    input  logic       clk,
    input  logic       st,
    input  logic       start_pulse,
    input  logic       pause_pulse,
    input  logic [6:0] preset_sec,
    input  logic       beep_over,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic       running,
    output logic       alarm_st,
    output logic       done,
    output logic       warn
);

    localparam int ALARM_CYC = ALARM_TO_SEC * CLK_HZ;
    localparam int PRE_W     = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam int ALM_W     = (ALARM_CYC > 1) ? $clog2(ALARM_CYC) : 1;
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(CLK_HZ - 1);
    localparam logic [ALM_W-1:0] ALM_MAX = ALM_W'(ALARM_CYC - 1);

    typedef enum logic [2:0] {IDLE, RUN, PAUSE, ALARM, DONE} state_t;

    state_t           state_q, state_d;
    logic [PRE_W-1:0] pre_q, pre_d;
    logic [ALM_W-1:0] alm_q, alm_d;
    logic [3:0]       tens_d, ones_d;
    logic [7:0]       load_bcd, dec_bcd;
    logic             wrap;

    // Clamp to 99 and split into {tens, ones}.
    function automatic logic [7:0] to_bcd(input logic [6:0] bin);
        logic [6:0] v;
        logic [3:0] t;
        v = (bin > 7'd99) ? 7'd99 : bin;
        t = 4'd0;
        for (int i = 1; i <= 9; i++) begin
            if (v >= 7'(i * 10)) t = 4'(i);
        end
        return {t, 4'(v - 7'(t) * 7'd10)};
    endfunction

    function automatic logic [7:0] bcd_dec(input logic [3:0] t, input logic [3:0] o);
        if (o == 4'd0) return {t - 4'd1, 4'd9};
        return {t, o - 4'd1};
    endfunction

    always_comb begin
        state_d  = state_q;
        pre_d    = pre_q;
        alm_d    = '0;
        tens_d   = sec_tens;
        ones_d   = sec_ones;
        load_bcd = to_bcd(preset_sec);
        dec_bcd  = bcd_dec(sec_tens, sec_ones);
        wrap     = (pre_q == PRE_MAX);

        if (start_pulse) begin
            tens_d  = load_bcd[7:4];
            ones_d  = load_bcd[3:0];
            pre_d   = '0;
            state_d = (load_bcd == 8'h00) ? ALARM : RUN;
        end else begin
            case (state_q)
                RUN: begin
                    // The pause edge still advances the prescaler, so resume continues mid-second.
                    pre_d = wrap ? '0 : pre_q + 1'b1;
                    if (wrap) begin
                        tens_d = dec_bcd[7:4];
                        ones_d = dec_bcd[3:0];
                    end
                    if (wrap && dec_bcd == 8'h00) state_d = ALARM;
                    else if (pause_pulse)         state_d = PAUSE;
                end
                PAUSE: begin
                    if (pause_pulse) state_d = RUN;
                end
                ALARM: begin
                    alm_d = alm_q + 1'b1;
                    if (beep_over || alm_q == ALM_MAX) state_d = DONE;
                end
                default: ;
            endcase
        end
    end

    // Status flags follow the registered state, so they trail a state change by one edge.
    always_ff @(posedge clk) begin
        if (!st) begin
            state_q  <= IDLE;
            pre_q    <= '0;
            alm_q    <= '0;
            sec_tens <= 4'd0;
            sec_ones <= 4'd0;
            running  <= 1'b0;
            alarm_st <= 1'b0;
            done     <= 1'b0;
        end else begin
            state_q  <= state_d;
            pre_q    <= pre_d;
            alm_q    <= alm_d;
            sec_tens <= tens_d;
            sec_ones <= ones_d;
            running  <= (state_q == RUN);
            alarm_st <= (state_q == ALARM);
            done     <= (state_q == DONE);
        end
    end

`ifdef COUNT_TIMER_WARN_EN
    logic warn_d;

    always_comb begin
        warn_d = (state_d == RUN || state_d == PAUSE) && (tens_d == 4'd0) &&
                 (ones_d inside {4'd1, 4'd2, 4'd3});
    end

    always_ff @(posedge clk) begin
        if (!st) warn <= 1'b0;
        else     warn <= warn_d;
    end
`else
    assign warn = 1'b0;
`endif

endmodule

// File: tb/tb_count_timer.sv
// Scoreboard bench for count_timer: stimulus queues timed output expectations, a negedge monitor
// pops one whenever the outputs change or an expectation falls due.
module tb_count_timer;

    logic       clk = 1'b0;
    logic       st = 1'b0;
    logic       start_pulse = 1'b0;
    logic       pause_pulse = 1'b0;
    logic [6:0] preset_sec = 7'd0;
    logic       beep_over = 1'b0;
    logic [3:0] sec_tens, sec_ones;
    logic       running, alarm_st, done, warn;

`ifdef COUNT_TIMER_WARN_EN
    localparam logic WEN = 1'b1;
`else
    localparam logic WEN = 1'b0;
`endif

    int          cyc = 0;
    int          n_tests = 0;
    int          n_fail = 0;
    logic        mon_on = 1'b0;
    logic        finish_req = 1'b0;
    int          q_cyc[$];
    logic [11:0] q_val[$];
    string       q_name[$];

    count_timer #(.CLK_HZ(4), .ALARM_TO_SEC(3)) dut (
        .clk(clk), .st(st), .start_pulse(start_pulse), .pause_pulse(pause_pulse),
        .preset_sec(preset_sec), .beep_over(beep_over), .sec_tens(sec_tens),
        .sec_ones(sec_ones), .running(running), .alarm_st(alarm_st), .done(done), .warn(warn)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic push(input int c, input logic [3:0] t, input logic [3:0] o, input logic r,
                        input logic a, input logic d, input logic w, input string nm);
        q_cyc.push_back(c);
        q_val.push_back({t, o, r, a, d, w});
        q_name.push_back(nm);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) step();
    endtask

    // Monitor / scoreboard
    initial begin
        logic [11:0] cur, prev, want;
        int          ec;
        string       nm;
        prev = '0;
        forever begin
            @(negedge clk);
            cur = {sec_tens, sec_ones, running, alarm_st, done, warn};
            if (finish_req) begin
                n_tests++;
                if (q_cyc.size() != 0) begin
                    n_fail++;
                    $display("FAIL sb_drain: got %0d pending expectations, required 0", q_cyc.size());
                end
                $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
                $finish;
            end
            if (mon_on && (cur !== prev || (q_cyc.size() > 0 && q_cyc[0] == cyc))) begin
                n_tests++;
                if (q_cyc.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_change: got outputs %h at cycle %0d, required no change",
                             cur, cyc);
                end else begin
                    ec   = q_cyc.pop_front();
                    want = q_val.pop_front();
                    nm   = q_name.pop_front();
                    if (cur !== want || cyc != ec) begin
                        n_fail++;
                        $display("FAIL %s: got outputs %h at cycle %0d, required %h at cycle %0d",
                                 nm, cur, cyc, want, ec);
                    end
                end
            end
            prev = cur;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Stimulus; output tuple order is tens, ones, running, alarm_st, done, warn
    initial begin
        int l, b, s, p, r, z, t;

        wait_until(1);
        mon_on = 1'b1;
        push(3, 0, 0, 0, 0, 0, 0, "reset_state");
        wait_until(3);
        st = 1'b1;

        // preset 3: one digit step per 4 cycles, alarm one edge after 00
        wait_until(5);
        start_pulse = 1'b1; preset_sec = 7'd3; l = cyc + 1;
        push(l,      0, 3, 0, 0, 0, WEN,  "t1_load");
        push(l + 1,  0, 3, 1, 0, 0, WEN,  "t1_run");
        push(l + 4,  0, 2, 1, 0, 0, WEN,  "t1_dig2");
        push(l + 8,  0, 1, 1, 0, 0, WEN,  "t1_dig1");
        push(l + 12, 0, 0, 1, 0, 0, 1'b0, "t1_dig0");
        push(l + 13, 0, 0, 0, 1, 0, 1'b0, "t1_alarm");
        step(); start_pulse = 1'b0;
        wait_until(l + 2);
        beep_over = 1'b1;
        step(); beep_over = 1'b0;

        // beep_over ends the alarm, then restart from DONE
        wait_until(l + 14);
        beep_over = 1'b1; b = cyc + 1;
        push(b + 1, 0, 0, 0, 0, 1, 1'b0, "t2_done");
        step(); beep_over = 1'b0;
        wait_until(b + 3);
        start_pulse = 1'b1; preset_sec = 7'd3; s = cyc + 1;
        push(s,     0, 3, 0, 0, 1, WEN, "t2_reload");
        push(s + 1, 0, 3, 1, 0, 0, WEN, "t2_run");
        push(s + 4, 0, 2, 1, 0, 0, WEN, "t2_dig2");
        step(); start_pulse = 1'b0;
        wait_until(s + 5);
        st = 1'b0;
        push(s + 6, 0, 0, 0, 0, 0, 1'b0, "t5_rst_run");
        step(); st = 1'b1;

        // preset 12 with pause/resume and a tens borrow
        wait_until(s + 8);
        start_pulse = 1'b1; preset_sec = 7'd12; l = cyc + 1;
        push(l,     1, 2, 0, 0, 0, 0, "t3_load");
        push(l + 1, 1, 2, 1, 0, 0, 0, "t3_run");
        push(l + 4, 1, 1, 1, 0, 0, 0, "t3_dig11");
        step(); start_pulse = 1'b0;
        wait_until(l + 4);
        pause_pulse = 1'b1; p = cyc + 1;
        push(p + 1,  1, 1, 0, 0, 0, 0, "t3_paused");
        push(p + 20, 1, 1, 0, 0, 0, 0, "t3_frozen");
        step(); pause_pulse = 1'b0;
        wait_until(p + 20);
        pause_pulse = 1'b1; r = cyc + 1;
        push(r + 1, 1, 1, 1, 0, 0, 0, "t3_resumed");
        push(r + 3, 1, 0, 1, 0, 0, 0, "t3_dig10");
        push(r + 7, 0, 9, 1, 0, 0, 0, "t3_borrow");
        step(); pause_pulse = 1'b0;

        // clamp 120 -> 99 (restart while running), then preset 0 from IDLE
        wait_until(r + 8);
        start_pulse = 1'b1; preset_sec = 7'd120; l = cyc + 1;
        push(l,     9, 9, 1, 0, 0, 0, "t4_clamp");
        push(l + 4, 9, 8, 1, 0, 0, 0, "t4_dig98");
        step(); start_pulse = 1'b0;
        wait_until(l + 5);
        st = 1'b0;
        push(l + 6, 0, 0, 0, 0, 0, 0, "t4_rst");
        step(); st = 1'b1;
        wait_until(l + 8);
        start_pulse = 1'b1; preset_sec = 7'd0; z = cyc + 1;
        push(z + 1,  0, 0, 0, 1, 0, 0, "t4_preset0_alarm");
        push(z + 13, 0, 0, 0, 0, 1, 0, "t5_timeout_done");
        step(); start_pulse = 1'b0;
        wait_until(z + 14);
        pause_pulse = 1'b1;
        push(z + 17, 0, 0, 0, 0, 1, 0, "t5_done_hold");
        step(); pause_pulse = 1'b0;

        // preset 5: warn window over 03..01
        wait_until(z + 18);
        start_pulse = 1'b1; preset_sec = 7'd5; l = cyc + 1;
        push(l,      0, 5, 0, 0, 1, 1'b0, "t6_load");
        push(l + 1,  0, 5, 1, 0, 0, 1'b0, "t6_run");
        push(l + 4,  0, 4, 1, 0, 0, 1'b0, "t6_dig4");
        push(l + 8,  0, 3, 1, 0, 0, WEN,  "t6_warn_on");
        push(l + 12, 0, 2, 1, 0, 0, WEN,  "t6_dig2");
        push(l + 16, 0, 1, 1, 0, 0, WEN,  "t6_dig1");
        push(l + 20, 0, 0, 1, 0, 0, 1'b0, "t6_warn_off");
        push(l + 21, 0, 0, 0, 1, 0, 1'b0, "t6_alarm");
        step(); start_pulse = 1'b0;

        // start together with pause: start wins, in ALARM and in RUN
        wait_until(l + 22);
        start_pulse = 1'b1; pause_pulse = 1'b1; preset_sec = 7'd2; s = cyc + 1;
        push(s,     0, 2, 0, 1, 0, WEN, "t6_restart_alarm");
        push(s + 1, 0, 2, 1, 0, 0, WEN, "t6_restart_run");
        step(); start_pulse = 1'b0; pause_pulse = 1'b0;
        wait_until(s + 2);
        start_pulse = 1'b1; pause_pulse = 1'b1; preset_sec = 7'd7; t = cyc + 1;
        push(t,     0, 7, 1, 0, 0, 0, "t6_start_beats_pause");
        push(t + 4, 0, 6, 1, 0, 0, 0, "t6_still_running");
        step(); start_pulse = 1'b0; pause_pulse = 1'b0;

        wait_until(t + 6);
        finish_req = 1'b1;
    end

endmodule
